dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 205 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-organised data memory that answers core load/store requests after a
// fixed number of wait states, with byte/halfword/word access and error flagging.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int          CNT_W   = $clog2(WAIT_CYCLES + 2);
    localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               enter_resp;
    logic               accept;

    logic               lat_we;
    logic [31:0]        lat_addr;
    logic [31:0]        lat_wdata;
    logic [1:0]         lat_size;
    logic               lat_unsigned;

    logic               op_we;
    logic [31:0]        op_addr;
    logic [31:0]        op_wdata;
    logic [1:0]         op_size;
    logic               op_unsigned;
    logic               op_err;
    logic [IDX_W-1:0]   op_idx;
    logic [31:0]        word_idx;

    logic [31:0]        rd_word;
    logic [31:0]        rd_shifted;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic [31:0]        load_data;
    logic [3:0]         wr_be;
    logic [31:0]        wr_data;

    logic [31:0]        rsp_rdata_q;
    logic               rsp_err_q;

    logic [31:0]        mem [DEPTH_WORDS];

    assign accept = req_valid && req_ready;

    // With zero wait states the commit happens on the accepting edge itself,
    // so the operation is taken straight from the request port while idle.
    assign op_we       = (state_q == IDLE) ? req_we       : lat_we;
    assign op_addr     = (state_q == IDLE) ? req_addr     : lat_addr;
    assign op_wdata    = (state_q == IDLE) ? req_wdata    : lat_wdata;
    assign op_size     = (state_q == IDLE) ? req_size     : lat_size;
    assign op_unsigned = (state_q == IDLE) ? req_unsigned : lat_unsigned;

    assign word_idx = {2'b00, op_addr[31:2]};
    assign op_idx   = op_addr[IDX_W+1:2];
    assign op_err   = (op_size == 2'b11)
                   || ((op_size == 2'b01) && op_addr[0])
                   || ((op_size == 2'b10) && (op_addr[1:0] != 2'b00))
                   || (word_idx >= DEPTH_U);

    assign rd_word    = mem[op_idx];
    assign rd_shifted = rd_word >> {op_addr[1:0], 3'b000};
    assign rd_byte    = rd_shifted[7:0];
    assign rd_half    = op_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = rd_word;
        wr_be     = 4'b1111;
        wr_data   = op_wdata;
        case (op_size)
            2'b00: begin
                load_data = op_unsigned ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
                wr_be     = 4'b0001 << op_addr[1:0];
                wr_data   = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                load_data = op_unsigned ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
                wr_be     = op_addr[1] ? 4'b1100 : 4'b0011;
                wr_data   = {2{op_wdata[15:0]}};
            end
            default: begin
                load_data = rd_word;
                wr_be     = 4'b1111;
                wr_data   = op_wdata;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Request latch and response registers; the response is frozen while in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_we       <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_size     <= '0;
            lat_unsigned <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            if (accept) begin
                lat_we       <= req_we;
                lat_addr     <= req_addr;
                lat_wdata    <= req_wdata;
                lat_size     <= req_size;
                lat_unsigned <= req_unsigned;
            end
            if (enter_resp) begin
                rsp_err_q   <= op_err;
                rsp_rdata_q <= (!op_we && !op_err) ? load_data : 32'h0;
            end else if ((state_q == RESP) && rsp_ready) begin
                rsp_err_q   <= 1'b0;
                rsp_rdata_q <= '0;
            end
        end
    end

    // Storage is deliberately outside reset so contents survive it.
    always_ff @(posedge clk) begin
        if (enter_resp && op_we && !op_err) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[op_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: one instance with two wait
// states and one with zero wait states.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        z_req_valid;
    logic        z_req_ready;
    logic        z_req_we;
    logic [31:0] z_req_addr;
    logic [31:0] z_req_wdata;
    logic [1:0]  z_req_size;
    logic        z_req_unsigned;
    logic        z_rsp_valid;
    logic        z_rsp_ready;
    logic [31:0] z_rsp_rdata;
    logic        z_rsp_err;

    int vectors;
    int miscompares;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_z (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (z_req_valid),
        .req_ready    (z_req_ready),
        .req_we       (z_req_we),
        .req_addr     (z_req_addr),
        .req_wdata    (z_req_wdata),
        .req_size     (z_req_size),
        .req_unsigned (z_req_unsigned),
        .rsp_valid    (z_rsp_valid),
        .rsp_ready    (z_rsp_ready),
        .rsp_rdata    (z_rsp_rdata),
        .rsp_err      (z_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Issues one request from a falling edge and walks to RESP, checking timing.
    task automatic applyStimulus(input string tag, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [1:0] size, input logic uns);
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        req_valid    = 1'b1;
        checkOutput({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput({tag, ".valid_e1"}, {31'b0, rsp_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, ".valid_e2"}, {31'b0, rsp_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, ".valid_e3"}, {31'b0, rsp_valid}, 32'd1);
        checkOutput({tag, ".ready_resp"}, {31'b0, req_ready}, 32'd0);
    endtask

    task automatic checkResp(input string tag, input logic [31:0] exp_data, input logic exp_err);
        checkOutput({tag, ".rdata"}, rsp_rdata, exp_data);
        checkOutput({tag, ".err"}, {31'b0, rsp_err}, {31'b0, exp_err});
    endtask

    task automatic releaseResp(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput({tag, ".valid_after"}, {31'b0, rsp_valid}, 32'd0);
        checkOutput({tag, ".ready_after"}, {31'b0, req_ready}, 32'd1);
    endtask

    task automatic transact(input string tag, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                            input logic [31:0] exp_data, input logic exp_err);
        applyStimulus(tag, we, addr, wdata, size, uns);
        checkResp(tag, exp_data, exp_err);
        releaseResp(tag);
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        rst_n          = 1'b0;
        req_valid      = 1'b0;
        req_we         = 1'b0;
        req_addr       = '0;
        req_wdata      = '0;
        req_size       = 2'b10;
        req_unsigned   = 1'b0;
        rsp_ready      = 1'b0;
        z_req_valid    = 1'b0;
        z_req_we       = 1'b0;
        z_req_addr     = '0;
        z_req_wdata    = '0;
        z_req_size     = 2'b10;
        z_req_unsigned = 1'b0;
        z_rsp_ready    = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst.rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("rst.rdata", rsp_rdata, 32'h0);
        checkOutput("rst.err", {31'b0, rsp_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst.req_ready", {31'b0, req_ready}, 32'd1);

        // Word store/load round trip
        transact("st_w10", 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0, 1'b0);
        transact("ld_w10", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0);

        // Byte store into lane 3, upper wdata bits must be ignored
        transact("st_b13", 1'b1, 32'h13, 32'h12345680, 2'b00, 1'b0, 32'h0, 1'b0);
        transact("ld_sb13", 1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 32'hFFFFFF80, 1'b0);
        transact("ld_ub13", 1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 32'h00000080, 1'b0);
        transact("ld_w10b", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'h80ADBEEF, 1'b0);
        transact("ld_ub11", 1'b0, 32'h11, 32'h0, 2'b00, 1'b1, 32'h000000BE, 1'b0);

        // Halfword loads and stores
        transact("ld_sh12", 1'b0, 32'h12, 32'h0, 2'b01, 1'b0, 32'hFFFF80AD, 1'b0);
        transact("ld_uh10", 1'b0, 32'h10, 32'h0, 2'b01, 1'b1, 32'h0000BEEF, 1'b0);
        transact("st_w14", 1'b1, 32'h14, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0);
        transact("st_h16", 1'b1, 32'h16, 32'hFFFF1234, 2'b01, 1'b0, 32'h0, 1'b0);
        transact("ld_w14", 1'b0, 32'h14, 32'h0, 2'b10, 1'b0, 32'h12340000, 1'b0);

        // Error cases, then confirm memory is unchanged
        transact("err_h11", 1'b0, 32'h11, 32'h0, 2'b01, 1'b0, 32'h0, 1'b1);
        transact("err_w12", 1'b0, 32'h12, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1);
        transact("err_sz3", 1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1);
        transact("err_oor", 1'b0, 32'h1000, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1);
        transact("err_st12", 1'b1, 32'h12, 32'hFFFFFFFF, 2'b10, 1'b0, 32'h0, 1'b1);
        transact("err_sth13", 1'b1, 32'h13, 32'hFFFFFFFF, 2'b01, 1'b0, 32'h0, 1'b1);
        transact("ld_w10c", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'h80ADBEEF, 1'b0);

        // Backpressure: hold RESP for five cycles while the request port changes
        applyStimulus("hold", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
        req_addr = 32'h14;
        req_size = 2'b11;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("hold%0d.valid", i), {31'b0, rsp_valid}, 32'd1);
            checkOutput($sformatf("hold%0d.ready", i), {31'b0, req_ready}, 32'd0);
            checkResp($sformatf("hold%0d", i), 32'h80ADBEEF, 1'b0);
        end
        releaseResp("hold");

        // Reset during the wait of a store drops the store
        transact("st_w20", 1'b1, 32'h20, 32'h11111111, 2'b10, 1'b0, 32'h0, 1'b0);
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h22222222;
        req_size  = 2'b10;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        checkOutput("rstw.valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("rstw.rdata", rsp_rdata, 32'h0);
        checkOutput("rstw.err", {31'b0, rsp_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rstw.ready", {31'b0, req_ready}, 32'd1);
        transact("ld_w20", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h11111111, 1'b0);

        // Zero wait-state instance
        z_req_we    = 1'b1;
        z_req_addr  = 32'h40;
        z_req_wdata = 32'hCAFEF00D;
        z_req_size  = 2'b10;
        z_req_valid = 1'b1;
        checkOutput("z_st.ready", {31'b0, z_req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        z_req_valid = 1'b0;
        checkOutput("z_st.valid", {31'b0, z_rsp_valid}, 32'd1);
        checkOutput("z_st.err", {31'b0, z_rsp_err}, 32'd0);
        z_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        z_rsp_ready = 1'b0;
        checkOutput("z_st.valid_after", {31'b0, z_rsp_valid}, 32'd0);

        z_req_we    = 1'b0;
        z_req_addr  = 32'h40;
        z_req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        z_req_valid = 1'b0;
        checkOutput("z_ld.valid", {31'b0, z_rsp_valid}, 32'd1);
        checkOutput("z_ld.rdata", z_rsp_rdata, 32'hCAFEF00D);
        z_req_addr = 32'h13;
        z_req_size = 2'b11;
        @(posedge clk);
        @(negedge clk);
        checkOutput("z_ld.valid_hold", {31'b0, z_rsp_valid}, 32'd1);
        checkOutput("z_ld.rdata_hold", z_rsp_rdata, 32'hCAFEF00D);
        checkOutput("z_ld.err_hold", {31'b0, z_rsp_err}, 32'd0);
        z_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        z_rsp_ready = 1'b0;
        checkOutput("z_ld.valid_after", {31'b0, z_rsp_valid}, 32'd0);
        checkOutput("z_ld.ready_after", {31'b0, z_req_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
